rsp_s2_prep_mul_sched: RTL and testbench
========================================

Name: rsp_s2_prep_mul_sched

Overview:
Frame-level scheduler that sequences the S2 prep multiplier (Y = x·w, complex or real/bypass).
- Accepts a frame command, pulls samples from an upstream valid/ready stream and fetches per-sample twiddles from a synchronous coefficient ROM.
- Presents time-aligned x/w/valid to the multiplier and holds the mode select (i_switch) stable for the whole frame, including pipeline drain.
- Signals frame completion and error conditions to the S2 prep top-level control.

Parameters:
SAMPLE_WIDTH, 32, sample width (packed {imag,real}).
TWIDDLE_WIDTH, 50, twiddle width (packed {d,c}).
ADDR_WIDTH, 10, twiddle ROM address width.
LEN_WIDTH, 12, frame length counter width.
DRAIN_TIMEOUT, 16, max idle cycles allowed in DRAIN without a multiplier output.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  frame start pulse
cfg_mode  in  1  1 = real/bypass, 0 = complex
cfg_len  in  LEN_WIDTH  samples in frame
cfg_base  in  ADDR_WIDTH  first twiddle address
busy  out  1  frame in progress
done  out  1  1-cycle frame-complete pulse
err  out  2  sticky: [0] start while busy, [1] drain timeout
s_valid  in  1  upstream sample valid
s_ready  out  1  upstream ready
s_data  in  SAMPLE_WIDTH  upstream sample
tw_rd_en  out  1  ROM read enable
tw_addr  out  ADDR_WIDTH  ROM address
tw_data  in  TWIDDLE_WIDTH  ROM data, valid 1 cycle after tw_rd_en
m_switch  out  1  to multiplier i_switch
m_x0_data  out  SAMPLE_WIDTH  to multiplier i_x0_data
m_w  out  TWIDDLE_WIDTH  to multiplier i_w
m_x0_valid  out  1  to multiplier i_x0_valid
m_y0_valid  in  1  from multiplier o_y0_valid

Behaviour:
- Reset: clk, rst_n asynchronous active-low. All outputs 0; state IDLE; counters 0; err cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on cfg_start, latch mode/len/base, set m_switch = cfg_mode, clear err, move to RUN (or to DONE if cfg_len == 0). m_switch changes only on this transition.
- RUN: s_ready = 1 while in_cnt < len. Accept = s_valid & s_ready.
  - On accept: in_cnt++; in complex mode also tw_rd_en = 1 with tw_addr = base + in_cnt (mod 2^ADDR_WIDTH; wraps silently).
  - Real mode: tw_rd_en = 0; m_w holds its last value.
- Alignment: s_data is registered 1 cycle. m_x0_data, m_x0_valid and m_w (= tw_data) appear together exactly 1 cycle after accept, so input-to-multiplier latency is 1.
- m_x0_valid is 0 on non-accept cycles. Gaps in s_valid are allowed, and m_w is never updated on a gap.
- RUN -> DRAIN on the cycle in_cnt reaches len (last accept).
- DRAIN: s_ready = 0. out_cnt counts m_y0_valid pulses in RUN and DRAIN.
  - When out_cnt == len, go to DONE.
  - An idle counter resets on each m_y0_valid. If it reaches DRAIN_TIMEOUT, set err[1] and go to DONE.
- DONE: done = 1 for 1 cycle; busy = 0 next cycle; return to IDLE. m_switch holds its value until the next start.
- busy = 1 in RUN, DRAIN and DONE.
- cfg_start while busy: ignored; sets err[0].
- cfg_start in the same cycle as done: ignored (busy still 1).
- Reset mid-frame: returns to IDLE immediately and discards in-flight counts.

Decomposition:
- Package rsp_s2_prep_pkg holds:
  - the state enum typedef (IDLE/RUN/DRAIN/DONE);
  - err bit index constants;
  - latency constants MUL_COMPLEX_VALID = 6 and MUL_REAL_VALID = 3, used by the bench for expected timing.
- No sub-module is required beyond the existing delay_data for the 1-cycle sample register; everything else is inline.

Test Plan:
- Complex frame: len = 4, base = 0x3FE, s_valid continuous. Expect:
  - tw_addr = 3FE, 3FF, 000, 001;
  - m_x0_valid high 4 cycles, starting 1 cycle after the first accept;
  - done 1 cycle after the 4th m_y0_valid;
  - err = 0.
- Real frame: len = 3, mode = 1. Expect:
  - tw_rd_en never high; m_switch = 1 from the start cycle until the next start;
  - 3 outputs, done pulse, busy falls.
- Gapped input: complex len = 5, with s_valid pattern 1,0,1,1,0,0,1,1. Expect m_x0_valid to mirror accepts delayed by 1 and m_w to change only on valid cycles.
- Start while busy: a second cfg_start during RUN. Expect it ignored, err[0] = 1, frame completes normally, and err clears on the next accepted start.
- Drain timeout: complex len = 2, with m_y0_valid forced low. Expect err[1] = 1 and done exactly 16 cycles after entering DRAIN.
- len = 0, plus async reset asserted mid-RUN of an 8-sample frame. Expect:
  - len = 0: done on the cycle after start, no s_ready;
  - reset: all outputs 0 immediately, and the next start behaves normally.

Source files
------------

// File: rtl/rsp_s2_prep_pkg.sv
// Shared types and constants for the S2 prep multiplier scheduler.
package rsp_s2_prep_pkg;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bit positions inside the sticky err vector.
  localparam int ERR_START_BUSY    = 0;
  localparam int ERR_DRAIN_TIMEOUT = 1;

  // Multiplier input-valid to output-valid latency per mode.
  localparam int MUL_COMPLEX_VALID = 6;
  localparam int MUL_REAL_VALID    = 3;

endpackage

// File: rtl/delay_data.sv
// One-cycle data register with load enable; holds its value when not loaded.
module delay_data #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data;

  // Capture the input on enabled cycles only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_data <= '0;
    else if (i_en) r_data <= i_data;
  end

  assign o_data = r_data;

endmodule

// File: rtl/rsp_s2_prep_mul_sched.sv
// Frame scheduler for the S2 prep multiplier: pulls samples, fetches twiddles,
// presents aligned x/w/valid, holds the mode select and reports done/errors.
module rsp_s2_prep_mul_sched
  import rsp_s2_prep_pkg::*;
#(
  parameter int SAMPLE_WIDTH  = 32,
  parameter int TWIDDLE_WIDTH = 50,
  parameter int ADDR_WIDTH    = 10,
  parameter int LEN_WIDTH     = 12,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  input  logic                     cfg_mode,
  input  logic [LEN_WIDTH-1:0]     cfg_len,
  input  logic [ADDR_WIDTH-1:0]    cfg_base,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               err,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [SAMPLE_WIDTH-1:0]  s_data,
  output logic                     tw_rd_en,
  output logic [ADDR_WIDTH-1:0]    tw_addr,
  input  logic [TWIDDLE_WIDTH-1:0] tw_data,
  output logic                     m_switch,
  output logic [SAMPLE_WIDTH-1:0]  m_x0_data,
  output logic [TWIDDLE_WIDTH-1:0] m_w,
  output logic                     m_x0_valid,
  input  logic                     m_y0_valid
);

  localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

  state_e                     r_state, w_state_nxt;
  logic                       r_mode;
  logic                       r_switch;
  logic [LEN_WIDTH-1:0]       r_len;
  logic [LEN_WIDTH-1:0]       r_in_cnt;
  logic [LEN_WIDTH-1:0]       r_out_cnt;
  logic [ADDR_WIDTH-1:0]      r_base;
  logic [IDLE_W-1:0]          r_idle_cnt;
  logic [1:0]                 r_err;
  logic                       r_x0_valid;
  logic                       r_tw_pend;
  logic [TWIDDLE_WIDTH-1:0]   r_w_hold;

  logic                       w_accept;
  logic                       w_last_in;
  logic                       w_last_out;
  logic                       w_timeout;
  logic [LEN_WIDTH-1:0]       w_in_inc;
  logic [LEN_WIDTH-1:0]       w_out_nxt;
  logic [IDLE_W-1:0]          w_idle_inc;

  assign s_ready    = (r_state == ST_RUN) && (r_in_cnt < r_len);
  assign w_accept   = s_valid & s_ready;
  assign w_in_inc   = r_in_cnt + LEN_WIDTH'(1);
  assign w_out_nxt  = r_out_cnt + LEN_WIDTH'(m_y0_valid);
  assign w_idle_inc = r_idle_cnt + IDLE_W'(1);
  assign w_last_in  = w_accept && (w_in_inc == r_len);
  assign w_last_out = (w_out_nxt == r_len);
  assign w_timeout  = !m_y0_valid && (w_idle_inc == IDLE_W'(DRAIN_TIMEOUT));

  // Twiddle address follows the sample index; wraps at the ROM size.
  assign tw_rd_en   = w_accept & ~r_mode;
  assign tw_addr    = r_base + ADDR_WIDTH'(r_in_cnt);

  // ROM data arrives one cycle after the read, alongside the registered sample;
  // between reads the last twiddle is held so m_w never moves on a gap.
  assign m_w        = r_tw_pend ? tw_data : r_w_hold;
  assign m_x0_valid = r_x0_valid;
  assign m_switch   = r_switch;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign err        = r_err;

  delay_data #(
    .WIDTH (SAMPLE_WIDTH)
  ) u_x0_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_accept),
    .i_data (s_data),
    .o_data (m_x0_data)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode.
  // NOTE: default assigned first so no path leaves w_state_nxt unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (cfg_start) w_state_nxt = (cfg_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (w_last_in) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_last_out || w_timeout) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame context, counters, alignment registers and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= 1'b0;
      r_switch   <= 1'b0;
      r_len      <= '0;
      r_base     <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_idle_cnt <= '0;
      r_err      <= '0;
      r_x0_valid <= 1'b0;
      r_tw_pend  <= 1'b0;
      r_w_hold   <= '0;
    end else begin
      r_x0_valid <= w_accept;
      r_tw_pend  <= tw_rd_en;
      if (r_tw_pend) r_w_hold <= tw_data;

      if (r_state == ST_IDLE) begin
        if (cfg_start) begin
          r_mode    <= cfg_mode;
          r_switch  <= cfg_mode;
          r_len     <= cfg_len;
          r_base    <= cfg_base;
          r_in_cnt  <= '0;
          r_out_cnt <= '0;
          r_err     <= '0;
        end
      end else if (cfg_start) begin
        r_err[ERR_START_BUSY] <= 1'b1;
      end

      if (w_accept) r_in_cnt <= w_in_inc;
      if ((r_state == ST_RUN) || (r_state == ST_DRAIN)) r_out_cnt <= w_out_nxt;

      if (r_state == ST_DRAIN) begin
        r_idle_cnt <= m_y0_valid ? '0 : w_idle_inc;
        if (w_timeout && !w_last_out) r_err[ERR_DRAIN_TIMEOUT] <= 1'b1;
      end else begin
        r_idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rsp_s2_prep_mul_sched.sv
// Directed bench for rsp_s2_prep_mul_sched with ROM and multiplier-latency models.
module tb_rsp_s2_prep_mul_sched;
  import rsp_s2_prep_pkg::*;

  localparam int SW = 32;
  localparam int TW = 50;
  localparam int AW = 10;
  localparam int LW = 12;
  localparam logic [SW-1:0] D0 = 32'hC0DE_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_mode = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [AW-1:0] cfg_base = '0;
  logic          busy, done, s_ready, tw_rd_en, m_switch, m_x0_valid, m_y0_valid;
  logic [1:0]    err;
  logic          s_valid = 1'b0;
  logic [SW-1:0] s_data = '0;
  logic [AW-1:0] tw_addr;
  logic [TW-1:0] tw_data = '0;
  logic [SW-1:0] m_x0_data;
  logic [TW-1:0] m_w;

  rsp_s2_prep_mul_sched dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .cfg_len(cfg_len), .cfg_base(cfg_base), .busy(busy), .done(done), .err(err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .tw_rd_en(tw_rd_en),
    .tw_addr(tw_addr), .tw_data(tw_data), .m_switch(m_switch), .m_x0_data(m_x0_data),
    .m_w(m_w), .m_x0_valid(m_x0_valid), .m_y0_valid(m_y0_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [TW-1:0] rom_word(input logic [AW-1:0] a);
    return {a, 30'h2AAA_AAAA, ~a};
  endfunction

  // Synchronous twiddle ROM.
  always @(posedge clk) if (tw_rd_en) tw_data <= rom_word(tw_addr);

  // Multiplier valid-latency model.
  logic [MUL_COMPLEX_VALID-1:0] pipe;
  logic y_force_low = 1'b0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pipe <= '0;
    else        pipe <= {pipe[MUL_COMPLEX_VALID-2:0], m_x0_valid};
  assign m_y0_valid = ~y_force_low &
                      (m_switch ? pipe[MUL_REAL_VALID-1] : pipe[MUL_COMPLEX_VALID-1]);

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event logs captured mid-cycle.
  int            acc_q[$], xv_q[$], y_q[$], done_q[$];
  logic [AW-1:0] addr_q[$];
  logic [SW-1:0] xd_q[$];
  logic [TW-1:0] xw_q[$];
  int            rdy_n, sw_bad, w_bad;
  logic          exp_sw;
  logic [TW-1:0] prev_w;
  bit            mon_en = 1'b0;

  always @(negedge clk) if (mon_en) begin
    if (s_valid && s_ready) acc_q.push_back(cyc);
    if (s_ready) rdy_n++;
    if (tw_rd_en) addr_q.push_back(tw_addr);
    if (m_x0_valid) begin
      xv_q.push_back(cyc);
      xd_q.push_back(m_x0_data);
      xw_q.push_back(m_w);
    end
    if (m_y0_valid) y_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
    if (busy && (m_switch != exp_sw)) sw_bad++;
    if ((m_w != prev_w) && !m_x0_valid) w_bad++;
    prev_w = m_w;
  end

  int   start_cyc, done_cyc;
  logic [1:0] err_first;

  task automatic run_frame(input string tag, input logic mode, input int len,
                           input logic [AW-1:0] base, input logic [31:0] pat,
                           input int extra_start_at, input int budget);
    int  sent;
    bit  got_done;
    acc_q.delete(); xv_q.delete(); y_q.delete(); done_q.delete();
    addr_q.delete(); xd_q.delete(); xw_q.delete();
    rdy_n = 0; sw_bad = 0; w_bad = 0; exp_sw = mode; prev_w = m_w;
    sent = 0; got_done = 1'b0; done_cyc = -1000; err_first = 2'b11;
    mon_en = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_mode = mode; cfg_len = LW'(len); cfg_base = base;
    @(negedge clk);
    start_cyc = cyc;
    for (int i = 0; i < budget && !got_done; i++) begin
      @(posedge clk); #1;
      cfg_start = (i == extra_start_at);
      if (cfg_start) begin cfg_mode = ~mode; cfg_len = LW'(7); cfg_base = '0; end
      s_valid = (i < 32) ? pat[i] : 1'b0;
      s_data  = D0 + SW'(sent);
      @(negedge clk);
      if (i == 0) err_first = err;
      if (s_valid && s_ready) sent++;
      if (done) begin got_done = 1'b1; done_cyc = cyc; end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; cfg_start = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    check({tag, "_done_seen"}, 64'(got_done), 64'(1));
    check({tag, "_busy_end"}, 64'(busy), 64'(0));
  endtask

  task automatic check_stream(input string tag, input int n, input logic [AW-1:0] wbase,
                              input logic use_rom, input logic [TW-1:0] hold_w);
    int bad;
    bad = 0;
    check({tag, "_nacc"}, 64'(acc_q.size()), 64'(n));
    check({tag, "_nxv"}, 64'(xv_q.size()), 64'(n));
    for (int k = 0; k < xv_q.size() && k < acc_q.size(); k++)
      if (xv_q[k] != acc_q[k] + 1) bad++;
    check({tag, "_xv_align"}, 64'(bad), 64'(0));
    for (int k = 0; k < xd_q.size() && k < n; k++) begin
      check($sformatf("%s_xd%0d", tag, k), 64'(xd_q[k]), 64'(D0 + SW'(k)));
      check($sformatf("%s_xw%0d", tag, k), 64'(xw_q[k]),
            64'(use_rom ? rom_word(wbase + AW'(k)) : hold_w));
    end
    check({tag, "_w_gap"}, 64'(w_bad), 64'(0));
    check({tag, "_sw_hold"}, 64'(sw_bad), 64'(0));
  endtask

  logic [AW-1:0] ea [4];
  int            gap_off [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", 64'({busy, done, err, s_ready, tw_rd_en, m_switch, m_x0_valid}), 64'(0));
    check("rst_addr", 64'(tw_addr), 64'(0));
    check("rst_w", 64'(m_w), 64'(0));
    check("rst_x", 64'(m_x0_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Complex frame, base wraps past the top of the ROM.
    run_frame("t1", 1'b0, 4, 10'h3FE, 32'hFFFF_FFFF, -1, 40);
    ea = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    check("t1_naddr", 64'(addr_q.size()), 64'(4));
    for (int k = 0; k < 4 && k < addr_q.size(); k++)
      check($sformatf("t1_addr%0d", k), 64'(addr_q[k]), 64'(ea[k]));
    check_stream("t1", 4, 10'h3FE, 1'b1, '0);
    check("t1_first_acc", 64'((acc_q.size() > 0) ? acc_q[0] - start_cyc : -1), 64'(1));
    check("t1_ny", 64'(y_q.size()), 64'(4));
    check("t1_done_after_y", 64'(done_cyc - ((y_q.size() > 0) ? y_q[$] : -1000)), 64'(1));
    check("t1_done_lat", 64'(done_cyc - start_cyc), 64'(12));
    check("t1_ndone", 64'(done_q.size()), 64'(1));
    check("t1_err", 64'(err), 64'(0));

    // Real/bypass frame: no ROM reads, m_w holds the last complex twiddle.
    run_frame("t2", 1'b1, 3, 10'h155, 32'hFFFF_FFFF, -1, 40);
    check("t2_naddr", 64'(addr_q.size()), 64'(0));
    check_stream("t2", 3, '0, 1'b0, rom_word(10'h001));
    check("t2_ny", 64'(y_q.size()), 64'(3));
    check("t2_done_lat", 64'(done_cyc - start_cyc), 64'(8));
    check("t2_sw_after", 64'(m_switch), 64'(1));

    // Gapped input: s_valid 1,0,1,1,0,0,1,1.
    run_frame("t3", 1'b0, 5, 10'h010, 32'h0000_00CD, -1, 40);
    gap_off = '{0, 2, 3, 6, 7};
    for (int k = 0; k < 5 && k < acc_q.size(); k++)
      check($sformatf("t3_acc%0d", k), 64'(acc_q[k] - start_cyc), 64'(1 + gap_off[k]));
    check_stream("t3", 5, 10'h010, 1'b1, '0);
    check("t3_done_lat", 64'(done_cyc - start_cyc), 64'(16));
    check("t3_sw", 64'(m_switch), 64'(0));

    // Second start during RUN is ignored but flagged.
    run_frame("t4", 1'b0, 3, 10'h100, 32'hFFFF_FFFF, 1, 40);
    check_stream("t4", 3, 10'h100, 1'b1, '0);
    check("t4_err", 64'(err), 64'(2'b01));
    check("t4_done_lat", 64'(done_cyc - start_cyc), 64'(11));
    check("t4_sw", 64'(m_switch), 64'(0));

    // Drain timeout with the multiplier output suppressed.
    y_force_low = 1'b1;
    run_frame("t5", 1'b0, 2, 10'h2A0, 32'hFFFF_FFFF, -1, 60);
    y_force_low = 1'b0;
    check("t5_err_cleared", 64'(err_first), 64'(0));
    check("t5_err", 64'(err), 64'(2'b10));
    check("t5_drain_len",
          64'(done_cyc - (((acc_q.size() > 0) ? acc_q[$] : -1000) + 1)), 64'(16));
    check("t5_done_lat", 64'(done_cyc - start_cyc), 64'(19));

    // Zero-length frame.
    run_frame("t6", 1'b0, 0, 10'h3FF, 32'hFFFF_FFFF, -1, 10);
    check("t6_done_lat", 64'(done_cyc - start_cyc), 64'(1));
    check("t6_ready", 64'(rdy_n), 64'(0));
    check("t6_naddr", 64'(addr_q.size()), 64'(0));
    check("t6_nxv", 64'(xv_q.size()), 64'(0));
    check("t6_err", 64'(err_first), 64'(0));

    // Asynchronous reset in the middle of an 8-sample real frame.
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_mode = 1'b1; cfg_len = LW'(8); cfg_base = '0;
    @(posedge clk); #1;
    cfg_start = 1'b0; s_valid = 1'b1; s_data = D0;
    repeat (3) @(posedge clk);
    #1;
    check("t7_pre", 64'({busy, m_switch, s_ready}), 64'(3'b111));
    check("t7_pre_w", 64'(m_w), 64'(rom_word(10'h2A1)));
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_ctl", 64'({busy, done, err, s_ready, tw_rd_en, m_switch, m_x0_valid}), 64'(0));
    check("t7_rst_addr", 64'(tw_addr), 64'(0));
    check("t7_rst_w", 64'(m_w), 64'(0));
    check("t7_rst_x", 64'(m_x0_data), 64'(0));
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("t8", 1'b0, 2, 10'h020, 32'hFFFF_FFFF, -1, 40);
    check("t8_naddr", 64'(addr_q.size()), 64'(2));
    for (int k = 0; k < 2 && k < addr_q.size(); k++)
      check($sformatf("t8_addr%0d", k), 64'(addr_q[k]), 64'(10'h020 + k));
    check_stream("t8", 2, 10'h020, 1'b1, '0);
    check("t8_done_lat", 64'(done_cyc - start_cyc), 64'(10));
    check("t8_err", 64'(err), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
